// File: rtl/seq_sig_pkg.sv
// Shared definitions for both ends of the 12-bit serial signature link.
// The generator and the receiver import the same signature constants.
package seq_sig_pkg;

  localparam int PAT_W = 12;
  localparam logic [PAT_W-1:0] PATTERN = 12'b000100010110;

  localparam int DEF_BIT_CLKS = 500000;
  localparam int DEF_CNT_W    = 19;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/sig_bit_sampler.sv
// Synchronises the asynchronous signature line, recovers bit phase from edges
// and samples each bit at mid-period.
module sig_bit_sampler #(
  parameter int BIT_CLKS = 500000,
  parameter int CNT_W    = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic samp_stb,
  output logic samp_bit,
  output logic data_bit,
  output logic data_vld
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP = CNT_W'(BIT_CLKS / 2 - 1);

  logic             sync1_reg, sync2_reg, sync3_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             data_bit_reg, data_bit_next;
  logic             data_vld_reg, data_vld_next;
  logic             sig_edge;

  assign sig_edge = sync2_reg ^ sync3_reg;

  // An edge re-centres the phase and always beats a coincident sample.
  always_comb begin
    cnt_next      = cnt_reg + CNT_W'(1);
    data_bit_next = data_bit_reg;
    data_vld_next = 1'b0;
    samp_stb      = 1'b0;
    samp_bit      = sync2_reg;
    if (sig_edge) begin
      cnt_next = '0;
    end else begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
      end
      if (cnt_reg == CNT_SAMP) begin
        samp_stb      = 1'b1;
        data_bit_next = sync2_reg;
        data_vld_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      sync3_reg    <= 1'b0;
      cnt_reg      <= '0;
      data_bit_reg <= 1'b0;
      data_vld_reg <= 1'b0;
    end else begin
      sync1_reg    <= sig;
      sync2_reg    <= sync1_reg;
      sync3_reg    <= sync2_reg;
      cnt_reg      <= cnt_next;
      data_bit_reg <= data_bit_next;
      data_vld_reg <= data_vld_next;
    end
  end

  assign data_bit = data_bit_reg;
  assign data_vld = data_vld_reg;

endmodule

// File: rtl/seq_pattern_rx.sv
// Signature link receiver: hunts for the signature, then tracks frame
// alignment bit by bit and counts mismatches.
module seq_pattern_rx #(
  parameter int                 BIT_CLKS = seq_sig_pkg::DEF_BIT_CLKS,
  parameter int                 PAT_W    = seq_sig_pkg::PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN  = seq_sig_pkg::PATTERN,
  parameter int                 CNT_W    = seq_sig_pkg::DEF_CNT_W
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG,
  output logic       oBIT,
  output logic       oBIT_VLD,
  output logic       oLOCK,
  output logic       oFRAME,
  output logic       oERR,
  output logic [7:0] oERRCNT
);

  import seq_sig_pkg::state_t;
  import seq_sig_pkg::HUNT;
  import seq_sig_pkg::LOCKED;

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  logic samp_stb, samp_bit;

  sig_bit_sampler #(
    .BIT_CLKS (BIT_CLKS),
    .CNT_W    (CNT_W)
  ) u_sampler (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .sig      (iSIG),
    .samp_stb (samp_stb),
    .samp_bit (samp_bit),
    .data_bit (oBIT),
    .data_vld (oBIT_VLD)
  );

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] sr_reg, sr_next, sr_upd;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             frame_reg, frame_next;
  logic             err_reg, err_next;
  logic [7:0]       errcnt_reg, errcnt_next;
  logic             exp_bit;

  assign sr_upd  = {sr_reg[PAT_W-2:0], samp_bit};
  assign exp_bit = PATTERN[IDX_LAST - idx_reg];

  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    idx_next    = idx_reg;
    frame_next  = 1'b0;
    err_next    = 1'b0;
    errcnt_next = errcnt_reg;
    if (samp_stb) begin
      sr_next = sr_upd;
      unique case (state_reg)
        HUNT: begin
          if (sr_upd == PATTERN) begin
            state_next = LOCKED;
            idx_next   = '0;
            frame_next = 1'b1;
          end
        end
        LOCKED: begin
          if (samp_bit == exp_bit) begin
            if (idx_reg == IDX_LAST) begin
              idx_next   = '0;
              frame_next = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            state_next = HUNT;
            idx_next   = '0;
            err_next   = 1'b1;
            if (errcnt_reg != 8'hFF) begin
              errcnt_next = errcnt_reg + 8'd1;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg  <= HUNT;
      sr_reg     <= '0;
      idx_reg    <= '0;
      frame_reg  <= 1'b0;
      err_reg    <= 1'b0;
      errcnt_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      idx_reg    <= idx_next;
      frame_reg  <= frame_next;
      err_reg    <= err_next;
      errcnt_reg <= errcnt_next;
    end
  end

  assign oLOCK   = (state_reg == LOCKED);
  assign oFRAME  = frame_reg;
  assign oERR    = err_reg;
  assign oERRCNT = errcnt_reg;

endmodule

// File: tb/tb_seq_pattern_rx.sv
// Directed bench for seq_pattern_rx with an 8-cycle bit period.
module tb_seq_pattern_rx;

  localparam int BC = 8;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iSIG = 1'b0;
  logic       oBIT, oBIT_VLD, oLOCK, oFRAME, oERR;
  logic [7:0] oERRCNT;

  seq_pattern_rx #(.BIT_CLKS(BC), .CNT_W(4)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iSIG     (iSIG),
    .oBIT     (oBIT),
    .oBIT_VLD (oBIT_VLD),
    .oLOCK    (oLOCK),
    .oFRAME   (oFRAME),
    .oERR     (oERR),
    .oERRCNT  (oERRCNT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic       b;
    logic       lock;
    logic       frame;
    logic       err;
    logic [7:0] cnt;
    int         cyc;
  } ev_t;

  ev_t  ev_q[$];
  int   cyc = 0;
  int   vld_total = 0;
  int   stray = 0;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] pat_v = 12'b000100010110;
  int   jlen[12] = '{10, 7, 6, 7, 10, 9, 9, 6, 6, 9, 9, 8};

  always @(posedge iCLK) cyc <= cyc + 1;

  // Every sample pulse is logged with the status outputs of that same cycle.
  always @(negedge iCLK) begin : mon
    ev_t e;
    if (oBIT_VLD) begin
      e.b = oBIT; e.lock = oLOCK; e.frame = oFRAME; e.err = oERR;
      e.cnt = oERRCNT; e.cyc = cyc;
      ev_q.push_back(e);
      vld_total++;
    end else if (oFRAME || oERR) begin
      stray++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    iSIG = b;
    repeat (len) @(posedge iCLK);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 12; i++) send_bit(pat_v[11-i], BC);
  endtask

  // A leading 1 fixes the phase; the log is cleared before its sample lands.
  task automatic preamble();
    iSIG = 1'b1;
    repeat (5) @(posedge iCLK);
    #1;
    ev_q.delete();
    repeat (3) @(posedge iCLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bit"},  int'(oBIT), 0);
    check({tag, "_vld"},  int'(oBIT_VLD), 0);
    check({tag, "_lock"}, int'(oLOCK), 0);
    check({tag, "_frm"},  int'(oFRAME), 0);
    check({tag, "_err"},  int'(oERR), 0);
    check({tag, "_cnt"},  int'(oERRCNT), 0);
  endtask

  initial begin : stim
    int vld_before;
    int nerr;

    // Reset with the line idle
    repeat (10) @(posedge iCLK);
    #1;
    check_outputs_zero("rst");
    check("rst_no_vld", vld_total, 0);
    iRST_N = 1'b1;
    send_bit(1'b0, 2 * BC);

    // Acquisition: preamble + three clean frames
    preamble();
    for (int f = 0; f < 3; f++) send_frame();
    check("acq_nev", ev_q.size(), 37);
    if (ev_q.size() == 37) begin
      check("acq_pre_bit", int'(ev_q[0].b), 1);
      for (int i = 1; i <= 36; i++) begin
        check($sformatf("acq_bit%0d", i),  int'(ev_q[i].b), int'(pat_v[11 - ((i - 1) % 12)]));
        check($sformatf("acq_frm%0d", i),  int'(ev_q[i].frame), (i % 12 == 0) ? 1 : 0);
        check($sformatf("acq_lock%0d", i), int'(ev_q[i].lock), (i >= 12) ? 1 : 0);
        check($sformatf("acq_err%0d", i),  int'(ev_q[i].err), 0);
      end
      check("acq_frm_gap1", ev_q[24].cyc - ev_q[12].cyc, 96);
      check("acq_frm_gap2", ev_q[36].cyc - ev_q[24].cyc, 96);
    end

    // Bit 7 inverted, then the signature restarts at once
    ev_q.delete();
    for (int i = 0; i < 8; i++) send_bit((i == 7) ? ~pat_v[11-i] : pat_v[11-i], BC);
    send_frame();
    check("err1_nev", ev_q.size(), 20);
    if (ev_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("err1_err%0d", i),  int'(ev_q[i].err), (i == 7) ? 1 : 0);
        check($sformatf("err1_lock%0d", i), int'(ev_q[i].lock), (i < 7 || i == 19) ? 1 : 0);
        check($sformatf("err1_frm%0d", i),  int'(ev_q[i].frame), (i == 19) ? 1 : 0);
      end
      check("err1_cnt", int'(ev_q[7].cnt), 1);
    end

    // Edge jitter of up to 2 cycles while locked
    ev_q.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 12; i++) send_bit(pat_v[11-i], jlen[i]);
    check("jit_nev", ev_q.size(), 36);
    if (ev_q.size() == 36) begin
      for (int i = 0; i < 36; i++) begin
        check($sformatf("jit_bit%0d", i),  int'(ev_q[i].b), int'(pat_v[11 - (i % 12)]));
        check($sformatf("jit_lock%0d", i), int'(ev_q[i].lock), 1);
        check($sformatf("jit_err%0d", i),  int'(ev_q[i].err), 0);
        check($sformatf("jit_frm%0d", i),  int'(ev_q[i].frame), (i % 12 == 11) ? 1 : 0);
      end
    end

    // 300 errors, relocking after each; count saturates at 255
    ev_q.delete();
    for (int k = 0; k < 300; k++) begin
      send_bit(1'b1, BC);
      send_frame();
    end
    check("sat_nev", ev_q.size(), 3900);
    if (ev_q.size() == 3900) begin
      nerr = 0;
      foreach (ev_q[i]) nerr += int'(ev_q[i].err);
      check("sat_nerr", nerr, 300);
      for (int k = 0; k < 300; k++) begin
        check($sformatf("sat_cnt%0d", k),  int'(ev_q[13*k].cnt), (k + 2 > 255) ? 255 : k + 2);
        check($sformatf("sat_err%0d", k),  int'(ev_q[13*k].err), 1);
        check($sformatf("sat_relock%0d", k), int'(ev_q[13*k+12].frame), 1);
      end
    end
    check("sat_final", int'(oERRCNT), 255);

    // Asynchronous reset in the middle of a locked frame
    for (int i = 0; i < 5; i++) send_bit(pat_v[11-i], BC);
    check("pre_rst_lock", int'(oLOCK), 1);
    check("pre_rst_cnt", int'(oERRCNT), 255);
    #2;
    iRST_N = 1'b0;
    #1;
    check_outputs_zero("arst");
    iSIG = 1'b0;
    vld_before = vld_total;
    repeat (20) @(posedge iCLK);
    #1;
    check("arst_no_vld", vld_total - vld_before, 0);
    check_outputs_zero("arst_hold");
    iRST_N = 1'b1;
    send_bit(1'b0, 2 * BC);
    preamble();
    send_frame();
    check("rlk_nev", ev_q.size(), 13);
    if (ev_q.size() == 13) begin
      check("rlk_lock11", int'(ev_q[11].lock), 0);
      check("rlk_frm11",  int'(ev_q[11].frame), 0);
      check("rlk_lock12", int'(ev_q[12].lock), 1);
      check("rlk_frm12",  int'(ev_q[12].frame), 1);
      check("rlk_cnt12",  int'(ev_q[12].cnt), 0);
    end

    check("stray_pulses", stray, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
